// File: rtl/trace_uart_tx.sv
// trace_uart_tx: captures core writeback records into a FIFO and streams each one
// as a 10-byte 8N1 UART frame (A5 sync, pc, reg, value; big-endian fields).
module trace_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        trace_en,
    input  logic                        debug_wb_ena,
    input  logic [31:0]                 debug_wb_pc,
    input  logic [4:0]                  debug_wb_reg,
    input  logic [31:0]                 debug_wb_value,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 overflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    byte_q, byte_d;
    logic [79:0]   frame_q, frame_d;
    logic          tx_q, tx_d;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   ovf_q;
    logic [68:0]   mem_q [FIFO_DEPTH];
    logic [68:0]   rec;
    logic [7:0]    next_byte;
    logic          full, req, push, drop, pop, baud_end;

    // Fullness comes from the registered count, so a pop in the same cycle never rescues a push.
    assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign req      = trace_en & debug_wb_ena;
    assign push     = req & ~full;
    assign drop     = req & full;
    assign pop      = (state_q == IDLE) && (cnt_q != '0);
    assign baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
    assign rec      = mem_q[rd_q];
    assign cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    assign uart_tx      = tx_q;
    assign busy         = (state_q != IDLE) || (cnt_q != '0);
    assign fifo_level   = cnt_q;
    assign overflow_cnt = ovf_q;

    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE || baud_end) ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: if (pop) begin
                state_d = START;
                byte_d  = '0;
                frame_d = {8'hA5, rec[68:37], 3'b000, rec[36:32], rec[31:0]};
            end
            START: if (baud_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (baud_end) begin
                state_d = (bit_q == 3'd7) ? STOP : DATA;
                bit_d   = bit_q + 3'd1;
            end
            STOP: if (baud_end) begin
                state_d = (byte_q < 4'd9) ? START : IDLE;
                byte_d  = byte_q + 4'd1;
                frame_d = {frame_q[71:0], 8'h00};
            end
            default: state_d = IDLE;
        endcase
        // The line is registered from the next state so each bit appears exactly on its edge.
        next_byte = frame_d[79:72];
        tx_d      = (state_d == START) ? 1'b0 : (state_d == DATA) ? next_byte[bit_d] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            tx_q    <= 1'b1;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_q] <= {debug_wb_pc, debug_wb_reg, debug_wb_value};
    end
endmodule

// File: tb/tb_trace_uart_tx.sv
// tb_trace_uart_tx: directed bench for trace_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4;
// decodes the UART line at fixed bit centres and compares against hand-built frames.
`timescale 1ns/1ps
module tb_trace_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_en = 1'b0;
    logic        ena = 1'b0;
    logic [31:0] pc = '0;
    logic [4:0]  rg = '0;
    logic [31:0] val = '0;
    logic        uart_tx, busy;
    logic [2:0]  level;
    logic [15:0] ovf;
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    trace_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .debug_wb_ena(ena),
        .debug_wb_pc(pc), .debug_wb_reg(rg), .debug_wb_value(val),
        .uart_tx(uart_tx), .busy(busy), .fifo_level(level), .overflow_cnt(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] fr(input logic [31:0] p, input logic [4:0] r, input logic [31:0] v);
        return {8'hA5, p, 3'b000, r, v};
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] p, input logic [4:0] r, input logic [31:0] v);
        pc = p;
        rg = r;
        val = v;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
    endtask

    // t_in < 0 searches for the start bit; otherwise t_in is the first negedge of the start bit.
    task automatic recv_chk(input int t_in, input logic [79:0] exp, input string tag, output int t0);
        logic [79:0] f;
        logic ferr;
        int t;
        int lim;
        f = 'x;
        ferr = 1'b0;
        t = t_in;
        if (t < 0) begin
            lim = cyc + 2000;
            while (uart_tx !== 1'b0 && cyc < lim) @(negedge clk);
            t = cyc;
            if (uart_tx !== 1'b0) ferr = 1'b1;
        end
        t0 = t;
        if (!ferr) begin
            for (int b = 0; b < 10; b++) begin
                for (int s = 0; s < 10; s++) begin
                    wait_cyc(t + 40 * b + 4 * s + 2);
                    if (s == 0) ferr |= (uart_tx !== 1'b0);
                    else if (s == 9) ferr |= (uart_tx !== 1'b1);
                    else f[72 - 8 * b + s - 1] = uart_tx;
                end
            end
        end
        chk(tag, f, exp);
        chk({tag, "_framing"}, ferr, 1'b0);
    endtask

    initial begin
        int c, t0, tp, lows;
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_ovf", ovf, 16'd0);
        rst_n = 1'b1;
        trace_en = 1'b1;
        @(negedge clk);

        // single record and push-to-start latency
        c = cyc;
        push(32'h0000_0010, 5'd5, 32'hDEAD_BEEF);
        chk("lat_level1", level, 3'd1);
        chk("lat_tx_high", uart_tx, 1'b1);
        @(negedge clk);
        chk("lat_tx_low", uart_tx, 1'b0);
        chk("lat_level0", level, 3'd0);
        chk("lat_busy", busy, 1'b1);
        recv_chk(c + 2, 80'hA5_00_00_00_10_05_DE_AD_BE_EF, "single", t0);
        wait_cyc(c + 402);
        chk("single_busy_done", busy, 1'b0);

        // overflow: six consecutive pulses, one dropped
        c = cyc;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    pc = 32'h100 + i;
                    rg = 5'(i);
                    val = 32'h1000 + i;
                    ena = 1'b1;
                    @(negedge clk);
                end
                ena = 1'b0;
                chk("ovf_level_peak", level, 3'd4);
                chk("ovf_cnt", ovf, 16'd1);
            end
            begin
                tp = c + 2;
                for (int k = 0; k < 5; k++) begin
                    recv_chk(k == 0 ? c + 2 : -1, fr(32'h100 + k, 5'(k), 32'h1000 + k), $sformatf("ovf_frame%0d", k), t0);
                    if (k > 0) chk("ovf_spacing", t0 - tp, 80'd401);
                    tp = t0;
                end
            end
        join
        wait_cyc(tp + 402);
        chk("ovf_busy_done", busy, 1'b0);

        // gating: no capture while trace_en=0
        trace_en = 1'b0;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            ena = 1'(i % 2 == 0);
            pc = 32'h5000 + i;
            @(negedge clk);
            if (uart_tx !== 1'b1 || level !== 3'd0) lows++;
        end
        ena = 1'b0;
        @(negedge clk);
        chk("gate_quiet", lows, 80'd0);
        chk("gate_level", level, 3'd0);
        chk("gate_busy", busy, 1'b0);
        trace_en = 1'b1;
        c = cyc;
        push(32'hCAFE_0001, 5'd0, 32'h0123_4567);
        fork
            recv_chk(c + 2, fr(32'hCAFE_0001, 5'd0, 32'h0123_4567), "gate_midframe", t0);
            begin
                wait_cyc(c + 150);
                trace_en = 1'b0;
            end
        join
        wait_cyc(c + 402);
        chk("gate_drained", busy, 1'b0);

        // reset in the middle of byte 3 with records still queued
        trace_en = 1'b1;
        c = cyc;
        push(32'h7, 5'd7, 32'h7);
        push(32'h8, 5'd8, 32'h8);
        push(32'h9, 5'd9, 32'h9);
        wait_cyc(c + 2 + 130);
        chk("pre_rst_level", level, 3'd2);
        rst_n = 1'b0;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        rst_n = 1'b1;
        chk("midrst_tx", uart_tx, 1'b1);
        chk("midrst_level", level, 3'd0);
        chk("midrst_ovf", ovf, 16'd0);
        chk("midrst_busy", busy, 1'b0);
        lows = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("no_residual", lows, 80'd0);
        chk("post_rst_busy", busy, 1'b0);

        // ten spaced records wrap the pointers, then three back to back
        for (int k = 0; k < 10; k++) begin
            c = cyc;
            push(32'h1111_0000 * k + 32'h40, 5'(k + 20), ~(32'h0F0F_0000 + k));
            recv_chk(c + 2, fr(32'h1111_0000 * k + 32'h40, 5'(k + 20), ~(32'h0F0F_0000 + k)), $sformatf("wrap%0d", k), t0);
            wait_cyc(c + 402);
        end
        c = cyc;
        for (int k = 0; k < 3; k++) push(32'hB000_0000 + k, 5'(31 - k), 32'h8000_0001 << k);
        tp = c + 2;
        for (int k = 0; k < 3; k++) begin
            recv_chk(k == 0 ? c + 2 : -1, fr(32'hB000_0000 + k, 5'(31 - k), 32'h8000_0001 << k), $sformatf("b2b%0d", k), t0);
            if (k > 0) chk("b2b_spacing", t0 - tp, 80'd401);
            tp = t0;
        end
        wait_cyc(tp + 402);
        chk("b2b_done", busy, 1'b0);

        // saturation of the drop counter
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        trace_en = 1'b1;
        pc = 32'hFFFF_FFFF;
        rg = 5'd31;
        val = 32'h0;
        ena = 1'b1;
        wait_cyc(cyc + 66000);
        chk("sat_cnt", ovf, 16'hFFFF);
        chk("sat_level", level, 3'd4);
        repeat (5) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk("sat_hold", ovf, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/trace_uart_tx.md
TRACE_UART_TX -- requirements
Module: trace_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200 baud); legal values are >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning trace FIFO entries; legal values are a power of 2 and >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-005 SHALL have port trace_en, input, 1 bit: capture enable.
REQ-006 SHALL have port debug_wb_ena, input, 1 bit: the core's writeback register-write strobe.
REQ-007 SHALL have port debug_wb_pc, input, 32 bits: PC of the writeback instruction.
REQ-008 SHALL have port debug_wb_reg, input, 5 bits: destination register.
REQ-009 SHALL have port debug_wb_value, input, 32 bits: writeback data.
REQ-010 SHALL have port uart_tx, output, 1 bit: serial line, 8N1, idle high.
REQ-011 SHALL have port busy, output, 1 bit: asserted when the FSM is not IDLE or the FIFO is non-empty.
REQ-012 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: current number of FIFO entries.
REQ-013 SHALL have port overflow_cnt, output, 16 bits: count of dropped records.

Function
REQ-014 SHALL push the 69-bit record {pc, reg, value} when trace_en=1, debug_wb_ena=1 and the FIFO is not full; rd=x0 writes are captured too.
REQ-015 SHALL drop a capture request made while the FIFO is full and increment overflow_cnt, saturating at 0xFFFF.
- Fullness is sampled before any same-cycle pop, so a push into a full FIFO is dropped even if a pop happens that cycle.
REQ-016 SHALL use a circular FIFO whose read and write pointers wrap at FIFO_DEPTH.
- fifo_level reflects push and pop on the following cycle.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_level unchanged.
REQ-017 SHALL implement the FSM states IDLE, START, DATA, STOP with these transitions:
- IDLE: when the FIFO is non-empty, pop one record into a shadow register, set byte index to 0, go to START.
- START: drive uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: shift out 8 bits LSB first, CLKS_PER_BIT cycles each, then go to STOP.
- STOP: drive uart_tx=1 for CLKS_PER_BIT cycles. If byte index < 9, increment it and go to START; otherwise go to IDLE.
REQ-018 SHALL transmit each record as a 10-byte frame, in order:
- byte 0: 0xA5.
- bytes 1-4: pc[31:24], pc[23:16], pc[15:8], pc[7:0].
- byte 5: {3'b000, reg}.
- bytes 6-9: value, big-endian.
REQ-019 SHALL insert no idle gap between bytes within a frame.
- A frame is 100*CLKS_PER_BIT cycles long.
- A back-to-back frame starts one cycle after STOP of byte 9 ends (the IDLE pop cycle).
REQ-020 SHALL give the following latency for a push at cycle N into an empty FIFO with the FSM in IDLE:
- fifo_level=1 at N+1.
- Pop at N+1.
- uart_tx=0 from N+2.
REQ-021 SHALL use trace_en only to gate capture; clearing it mid-frame neither truncates the current frame nor stops the FIFO from draining.
REQ-022 SHALL drive uart_tx high in IDLE and STOP, and SHALL drive it from a register so it is glitch-free.

Reset
REQ-023 SHALL, in any cycle where rst_n=0 at the clock edge, do all of the following:
- set uart_tx=1, FSM=IDLE, fifo_level=0, overflow_cnt=0, busy=0, and FIFO pointers to 0;
- clear the bit counter and baud counter;
- never push into the FIFO.
REQ-024 SHALL, on reset asserted mid-frame, abort the frame with uart_tx=1 from the next edge, and SHALL NOT resume the aborted frame after reset is released.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-025 SHALL cover single record: pc=0x00000010, reg=5, value=0xDEADBEEF, one-cycle ena.
- Required bytes: A5 00 00 00 10 05 DE AD BE EF.
- uart_tx low 2 cycles after the push.
- busy=0 after 400 cycles.
REQ-026 SHALL cover overflow: 6 ena pulses on consecutive cycles while idle.
- 1 record popped immediately, 4 queued, 1 dropped.
- Expect overflow_cnt=1 and fifo_level=4 at the peak.
- 5 frames output.
REQ-027 SHALL cover gating: trace_en=0 with ena pulses, giving no push, fifo_level=0 and uart_tx=1 throughout.
- Then clear trace_en mid-frame: the frame completes intact.
REQ-028 SHALL cover reset mid-frame: rst_n=0 during byte 3.
- uart_tx=1 next cycle; fifo_level=0; overflow_cnt=0.
- After release, no residual frame.
REQ-029 SHALL cover wrap and back-to-back: 10 records pushed at one per 400 cycles, then 3 pushed together.
- All frames are correct with pointers wrapping.
- Consecutive frames are separated by exactly one idle cycle.
REQ-030 SHALL cover saturation: force 0x10000 or more drops, giving overflow_cnt held at 0xFFFF.
